// File: rtl/mul_pkg.sv
// Shared floating-point multiplier definitions: format widths, product width
// and the packed result layout.
package mul_pkg;

  localparam int unsigned FMT_SIGN_W = 1;
  localparam int unsigned FMT_EXPO_W = 8;
  localparam int unsigned FMT_MANT_W = 23;
  localparam int unsigned FMT_P      = 2 * FMT_MANT_W + 2;

  typedef struct packed {
    logic                  sign;
    logic [FMT_EXPO_W-1:0] expo;
    logic [FMT_MANT_W-1:0] mant;
  } fp_t;

endpackage

// File: rtl/mul2_norm_round_if.sv
// Stage-2 multiplier bus: stage-1 operands in, packed IEEE result and flags out.
interface mul2_norm_round_if
  import mul_pkg::*;
#(
  parameter int unsigned SIGN_W = FMT_SIGN_W,
  parameter int unsigned EXPO_W = FMT_EXPO_W,
  parameter int unsigned MANT_W = FMT_MANT_W
);
  localparam int unsigned ZERO_D = $clog2(MANT_W + 1);
  localparam int unsigned P      = 2 * MANT_W + 2;

  logic                              in_valid;
  logic                              in_ready;
  logic                              sign_1;
  logic [EXPO_W+1:0]                 expo_1;
  logic [ZERO_D:0]                   l_shift;
  logic [ZERO_D:0]                   r_shift;
  logic [P-1:0]                      prod;
  logic                              out_valid;
  logic                              out_ready;
  logic [SIGN_W+EXPO_W+MANT_W-1:0]   result;
  logic                              overflow;
  logic                              underflow;
  logic                              inexact;

  modport master (
    output in_valid, sign_1, expo_1, l_shift, r_shift, prod, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, sign_1, expo_1, l_shift, r_shift, prod, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact
  );

endinterface

// File: rtl/mul_round_rne.sv
// Round-to-nearest-even on a significand with hidden bit; renormalises on
// mantissa carry-out by bumping the exponent.
module mul_round_rne
  import mul_pkg::*;
#(
  parameter int unsigned MANT_W = FMT_MANT_W,
  parameter int unsigned EXPO_W = FMT_EXPO_W + 3
) (
  input  logic [MANT_W:0]          mant_in,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [EXPO_W-1:0] expo_in,
  output logic [MANT_W:0]          mant_out,
  output logic signed [EXPO_W-1:0] expo_out,
  output logic                     carry
);

  logic             round_up;
  logic [MANT_W+1:0] sum;

  assign round_up = guard & (sticky | mant_in[0]);
  assign sum      = {1'b0, mant_in} + {{(MANT_W+1){1'b0}}, round_up};
  assign carry    = sum[MANT_W+1];
  assign mant_out = carry ? sum[MANT_W+1:1] : sum[MANT_W:0];
  assign expo_out = carry ? expo_in + EXPO_W'(1) : expo_in;

endmodule

// File: rtl/mul2_norm_round.sv
// Final multiplier stage: register stage-1 outputs, normalise, round RNE,
// handle overflow/subnormal/zero and pack, behind a two-bank skid pipeline.
module mul2_norm_round
  import mul_pkg::*;
#(
  parameter int unsigned SIGN_W = FMT_SIGN_W,
  parameter int unsigned EXPO_W = FMT_EXPO_W,
  parameter int unsigned MANT_W = FMT_MANT_W
) (
  input logic              clk,
  input logic              rst_n,
  mul2_norm_round_if.slave bus
);

  localparam int unsigned ZERO_D   = $clog2(MANT_W + 1);
  localparam int unsigned P        = 2 * MANT_W + 2;
  localparam int unsigned XW       = EXPO_W + 3;
  localparam int unsigned RES_W    = SIGN_W + EXPO_W + MANT_W;
  localparam int unsigned EXPO_MAX = (1 << EXPO_W) - 1;

  logic              a_valid;
  logic              a_sign;
  logic [EXPO_W+1:0] a_expo;
  logic [ZERO_D:0]   a_lsh;
  logic [ZERO_D:0]   a_rsh;
  logic [P-1:0]      a_prod;

  logic              b_valid;
  logic [RES_W-1:0]  b_result;
  logic              b_ovf;
  logic              b_udf;
  logic              b_inx;

  logic a_load;
  logic b_load;

  assign b_load       = a_valid && (!b_valid || bus.out_ready);
  assign bus.in_ready = !a_valid || b_load;
  assign a_load       = bus.in_valid && bus.in_ready;

  // Normalise so the leading one sits at bit P-1 in both carry cases.
  logic              carry;
  logic [P-1:0]      nrm;
  logic signed [XW-1:0] expo_s;
  logic signed [XW-1:0] expo_n;
  logic              sub;
  logic [ZERO_D:0]   rsh;
  logic [2*P-1:0]    wide;
  logic [P-1:0]      shd;
  logic              lost;

  assign carry  = a_prod[P-1];
  assign nrm    = carry ? a_prod : ({a_prod[P-2:0], 1'b0} << a_lsh);
  assign expo_s = {a_expo[EXPO_W+1], a_expo};
  assign expo_n = carry ? expo_s + XW'(1) : expo_s - XW'(a_lsh);
  assign sub    = expo_s[XW-1] || (expo_s == '0);

  always_comb begin
    rsh = '0;
    if (sub) begin
      if (!carry)
        rsh = a_rsh;
      else if (a_rsh != '0)
        rsh = a_rsh - (ZERO_D+1)'(1);
    end
  end

  // Low half of the widened shift collects every bit pushed below the LSB.
  assign wide = {nrm, {P{1'b0}}} >> rsh;
  assign shd  = wide[2*P-1:P];
  assign lost = |wide[P-1:0];

  logic [MANT_W:0]      sig_pre;
  logic                 guard;
  logic                 sticky;
  logic signed [XW-1:0] expo_pre;
  logic [MANT_W:0]      sig_r;
  logic signed [XW-1:0] expo_r;
  logic                 rnd_carry;

  assign sig_pre  = shd[P-1 -: MANT_W+1];
  assign guard    = shd[P-2-MANT_W];
  assign sticky   = (|shd[P-3-MANT_W:0]) | lost;
  assign expo_pre = sub ? XW'(1) : expo_n;

  mul_round_rne #(
    .MANT_W (MANT_W),
    .EXPO_W (XW)
  ) u_rne (
    .mant_in  (sig_pre),
    .guard    (guard),
    .sticky   (sticky),
    .expo_in  (expo_pre),
    .mant_out (sig_r),
    .expo_out (expo_r),
    .carry    (rnd_carry)
  );

  logic             zero;
  logic             ovf;
  logic             hidden_r;
  logic             inx_r;
  logic [RES_W-1:0] res_n;
  logic             ovf_n;
  logic             udf_n;
  logic             inx_n;

  assign zero     = (a_prod == '0);
  assign hidden_r = sig_r[MANT_W] | rnd_carry;
  assign ovf      = !expo_r[XW-1] && (expo_r[XW-2:0] >= (XW-1)'(EXPO_MAX));
  assign inx_r    = guard | sticky;

  always_comb begin
    res_n = {{SIGN_W{a_sign}}, (hidden_r ? expo_r[EXPO_W-1:0] : {EXPO_W{1'b0}}),
             sig_r[MANT_W-1:0]};
    ovf_n = 1'b0;
    inx_n = inx_r;
    udf_n = inx_r && sub && !sig_pre[MANT_W];
    if (zero) begin
      res_n = {{SIGN_W{a_sign}}, {(EXPO_W+MANT_W){1'b0}}};
      inx_n = 1'b0;
      udf_n = 1'b0;
    end else if (ovf) begin
      res_n = {{SIGN_W{a_sign}}, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
      ovf_n = 1'b1;
      inx_n = 1'b1;
      udf_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      a_valid <= 1'b0;
    else if (a_load)
      a_valid <= 1'b1;
    else if (b_load)
      a_valid <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sign <= 1'b0;
      a_expo <= '0;
      a_lsh  <= '0;
      a_rsh  <= '0;
      a_prod <= '0;
    end else if (a_load) begin
      a_sign <= bus.sign_1;
      a_expo <= bus.expo_1;
      a_lsh  <= bus.l_shift;
      a_rsh  <= bus.r_shift;
      a_prod <= bus.prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      b_valid <= 1'b0;
    else if (b_load)
      b_valid <= 1'b1;
    else if (bus.out_ready)
      b_valid <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_result <= '0;
      b_ovf    <= 1'b0;
      b_udf    <= 1'b0;
      b_inx    <= 1'b0;
    end else if (b_load) begin
      b_result <= res_n;
      b_ovf    <= ovf_n;
      b_udf    <= udf_n;
      b_inx    <= inx_n;
    end
  end

  assign bus.out_valid = b_valid;
  assign bus.result    = b_result;
  assign bus.overflow  = b_ovf;
  assign bus.underflow = b_udf;
  assign bus.inexact   = b_inx;

endmodule

// File: tb/tb_mul2_norm_round.sv
// Directed bench for mul2_norm_round (FP32): rounding, overflow, subnormal,
// backpressure and mid-burst reset with hand-computed results.
module tb_mul2_norm_round;
  import mul_pkg::*;

  localparam int unsigned E  = FMT_EXPO_W;
  localparam int unsigned M  = FMT_MANT_W;
  localparam int unsigned ZD = $clog2(M + 1);
  localparam int unsigned PW = FMT_P;
  localparam logic [PW-1:0] P1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acc = 0;

  mul2_norm_round_if #(.SIGN_W(1), .EXPO_W(E), .MANT_W(M)) bus ();

  mul2_norm_round #(.SIGN_W(1), .EXPO_W(E), .MANT_W(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input int e, input int ls, input int rs,
                       input logic [PW-1:0] p);
    bus.sign_1  = s;
    bus.expo_1  = (E+2)'(e);
    bus.l_shift = (ZD+1)'(ls);
    bus.r_shift = (ZD+1)'(rs);
    bus.prod    = p;
  endtask

  // Entered just after a rising edge with an empty pipeline and out_ready high.
  task automatic run_vec(input string tag, input logic s, input int e, input int ls,
                         input int rs, input logic [PW-1:0] p, input logic [31:0] xr,
                         input logic xo, input logic xu, input logic xi);
    drive(s, e, ls, rs, p);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check({tag, ".in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".early_valid"}, bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".out_valid"}, bus.out_valid, 1);
    check({tag, ".result"}, bus.result, xr);
    check({tag, ".overflow"}, bus.overflow, xo);
    check({tag, ".underflow"}, bus.underflow, xu);
    check({tag, ".inexact"}, bus.inexact, xi);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_exp [4];
    bp_exp[0] = 32'h3F80_0000;
    bp_exp[1] = 32'h4000_0000;
    bp_exp[2] = 32'h4080_0000;
    bp_exp[3] = 32'h4100_0000;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, '0);
    #3;
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.result", bus.result, 0);
    check("rst.overflow", bus.overflow, 0);
    check("rst.underflow", bus.underflow, 0);
    check("rst.inexact", bus.inexact, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    //       tag           s  expo ls rs  prod                                     result        ov uf ix
    run_vec("one",        0, 127, 0, 0, P1 << 46,                                 32'h3F80_0000, 0, 0, 0);
    run_vec("sq15",       0, 127, 0, 0, (P1 << 47) | (P1 << 44),                  32'h4010_0000, 0, 0, 0);
    run_vec("neg_sq15",   1, 127, 0, 0, (P1 << 47) | (P1 << 44),                  32'hC010_0000, 0, 0, 0);
    run_vec("ovf",        0, 254, 0, 0, P1 << 47,                                 32'h7F80_0000, 1, 0, 1);
    run_vec("max_norm",   0, 254, 0, 0, P1 << 46,                                 32'h7F00_0000, 0, 0, 0);
    run_vec("ovf_rnd",    0, 254, 0, 0, (P1 << 47) - (P1 << 22),                  32'h7F80_0000, 1, 0, 1);
    run_vec("tie_even",   0, 127, 0, 0, (P1 << 46) | (P1 << 22),                  32'h3F80_0000, 0, 0, 1);
    run_vec("tie_odd",    0, 127, 0, 0, (P1 << 46) | (P1 << 23) | (P1 << 22),     32'h3F80_0002, 0, 0, 1);
    run_vec("tie_carry",  0, 127, 0, 0, (P1 << 47) - (P1 << 22),                  32'h4000_0000, 0, 0, 1);
    run_vec("above_half", 0, 127, 0, 0, (P1 << 46) | (P1 << 22) | P1,             32'h3F80_0001, 0, 0, 1);
    run_vec("below_half", 0, 127, 0, 0, (P1 << 46) | P1,                          32'h3F80_0000, 0, 0, 1);
    run_vec("lshift",     0, 127, 6, 0, P1 << 40,                                 32'h3C80_0000, 0, 0, 0);
    run_vec("zero",       1, 127, 0, 0, '0,                                       32'h8000_0000, 0, 0, 0);
    run_vec("sub",        0,  -2, 0, 3, P1 << 46,                                 32'h0010_0000, 0, 0, 0);
    run_vec("sub_inx",    0,  -2, 0, 3, (P1 << 46) | P1,                          32'h0010_0000, 0, 1, 1);
    run_vec("sub_to_nrm", 0,   0, 0, 1, (P1 << 47) - P1,                          32'h0080_0000, 0, 1, 1);
    run_vec("carry_e0",   0,   0, 0, 1, P1 << 47,                                 32'h0080_0000, 0, 0, 0);
    run_vec("min_sub",    0, -23, 0, 24, (P1 << 46) | P1,                         32'h0000_0001, 0, 1, 1);
    run_vec("deep_sub",   0, -40, 0, 41, P1 << 46,                                32'h0000_0000, 0, 1, 1);

    bus.out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        logic acc;
        for (int i = 0; i < 4; i++) begin
          drive(0, 127 + i, 0, 0, P1 << 46);
          bus.in_valid = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
              @(posedge clk);
              #1;
              acc = 1'b1;
              n_acc++;
            end
          end
          if (!acc) check("bp.accept_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
      end
      begin
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(negedge clk);
          seen = bus.out_valid;
        end
        check("bp.first_valid", seen, 1);
        check("bp.in_ready_drop", bus.in_ready, 0);
        check("bp.accepts_before_drop", n_acc, 2);
        for (int s = 0; s < 3; s++) begin
          if (s > 0) @(negedge clk);
          check("bp.stall_valid", bus.out_valid, 1);
          check("bp.stall_result", bus.result, bp_exp[0]);
          check("bp.stall_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          seen = 1'b0;
          for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = bus.out_valid;
          end
          check("bp.drain_valid", seen, 1);
          check("bp.drain_result", bus.result, bp_exp[k]);
          @(posedge clk);
          #1;
        end
      end
    join
    @(negedge clk);
    check("bp.empty", bus.out_valid, 0);
    @(posedge clk);
    #1;

    bus.out_ready = 1'b0;
    drive(0, 127, 0, 0, P1 << 46);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 drive(0, 128, 0, 0, P1 << 46);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("rstmid.pre_valid", bus.out_valid, 1);
    check("rstmid.pre_result", bus.result, 32'h3F80_0000);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.out_valid", bus.out_valid, 0);
    check("rstmid.result", bus.result, 0);
    check("rstmid.in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rstmid.no_stale", bus.out_valid, 0);
    @(posedge clk);
    #1;
    run_vec("post_rst",   0, 128, 0, 0, P1 << 46,                                 32'h4000_0000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul2_norm_round.md
# mul2_norm_round

Second (final) pipeline stage of the two-stage floating-point multiplier. It consumes stage 1's sign, biased exponent and shift amounts together with the raw significand product. It registers them, normalises the product, rounds to nearest-even, handles overflow, underflow and subnormals, and packs the IEEE-754 result. A valid/ready handshake on both sides, with two internal register banks, provides full-throughput pipelining with lossless backpressure.

## Interface
- SIGN_W, 1, sign field width
- EXPO_W, 8, exponent field width
- MANT_W, 23, stored mantissa width
- ZERO_D, $clog2(MANT_W+1), localparam; width base for shift amounts
- P, 2*MANT_W+2, localparam; product width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  stage-1 outputs and product are valid
- in_ready  out  1  block accepts this cycle
- sign_1  in  1  product sign
- expo_1  in  EXPO_W+2  signed two's-complement biased exponent, valid for a product in [1,2)
- l_shift  in  ZERO_D+1  left shift that normalises a product with leading zeros (subnormal operand), already limited so the exponent stays ≥1
- r_shift  in  ZERO_D+1  right shift for a subnormal result (1−expo_1 when expo_1≤0, else 0), saturated
- prod  in  P  unsigned significand product; bits [P-1:P-2] are integer bits
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  SIGN_W+EXPO_W+MANT_W  packed {sign, exponent, mantissa}
- overflow, underflow, inexact  out  1 each  IEEE flags, aligned with result

## Operation
- Bank A (reg2) captures the inputs when in_valid && in_ready. Normalise and round are combinational from bank A. Bank B captures the packed result and flags.
- Stall rule:
  - B loads when A is valid and (B empty or out_ready).
  - in_ready = !A_valid || B_load.
  - Simultaneous accept and drain in the same cycle is legal and loses nothing.
- Normalise: carry c = prod[P-1].
  - c=1: shift right 1, exponent e = expo_1+1.
  - c=0: shift left by l_shift, e = expo_1 − l_shift.
- Subnormal: when expo_1 ≤ 0, apply a right shift of r_shift − c (floored at 0). Shifted-out bits OR into sticky. The result exponent field is 0, or becomes 1 if rounding carries into the hidden bit.
- Round to nearest-even: guard = first bit below the LSB, sticky = OR of all lower bits. Round up iff guard && (sticky || lsb). If the mantissa carries out, increment e and renormalise.
- Overflow: e ≥ 2^EXPO_W−1 after rounding. Result is ±inf (expo all-ones, mant 0); overflow=1, inexact=1.
- prod == 0: result is ±0, all flags 0.
- Right shift ≥ MANT_W+2: mantissa collapses to sticky. The result is ±0, or ±min-subnormal if rounding carries.
- inexact = guard || sticky. underflow = inexact && (pre-round result was subnormal).
- No NaN/inf input decode; special-operand bypass is handled elsewhere.

## Timing
- Latency 2 cycles: accept at edge N, out_valid at edge N+2 when out_ready is held high. Throughput is 1 per cycle.
- Reset (async assert, sync release):
  - A_valid = 0, B_valid = 0, out_valid = 0.
  - result = 0; overflow, underflow, inexact = 0.
  - in_ready = 1 from the first cycle after release.
- Reset mid-operation discards both banks; no partial result is ever presented.
- While out_valid && !out_ready, result and flags hold stable. A holds once B is full, and in_ready drops.
- Data registers load only on their enable, so there is no toggling on stalls.

## Structure
- Shared package mul_pkg: P, the fmt field-width constants, and the packed-result typedef.
- One sub-module, mul_round_rne: takes the pre-round mantissa, guard, sticky and exponent, and returns the rounded mantissa, exponent and carry-out. It is reusable for the adder path.
- Normalise shift and packing stay in the top module.

## Test plan
- 1.0×1.0 (FP32): sign_1=0, expo_1=127, prod=1<<46, shifts 0 → result 0x3F800000, no flags, out_valid 2 cycles after accept.
- 1.5×1.5: expo_1=127, prod bits 47 and 44 set → 0x40100000, inexact=0.
- Overflow: expo_1=254, prod=1<<47 → 0x7F800000, overflow=1, inexact=1.
- RNE ties:
  - guard=1, sticky=0, lsb=0 → truncated.
  - Same with lsb=1 → incremented.
  - All-ones mantissa tie with lsb=1 → carry to next exponent.
- Subnormal: expo_1=−2, r_shift=3, prod=1<<46 → 0x00100000, underflow=0, inexact=0. Add a low bit to prod → inexact=1, underflow=1.
- Backpressure: 4 back-to-back inputs, out_ready low for 3 cycles, then high. Required response:
  - in_ready drops after 2 accepts.
  - Results emerge in order, unchanged while stalled.
  - Reset asserted mid-burst clears out_valid immediately.
